mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares one word-addressed memory request port between an instruction requester (I) and a data requester (D).
- The memory port is the same valid/ready request, one-way-write, read-response interface used by the backing memory models. Those models accept in one cycle and return read data one cycle later, but this block makes no latency assumption.
- Arbitration is round-robin. Read-response ownership is tracked in an in-order tag FIFO so each response returns to the requester that issued the read.
- Sits between the CPU front-end/LSU and the memory (uncached memory model or cache).

Parameters:
- CPU_WIDTH, 32, data word width in bits.
- WORD_ADDR_BITS, 30, word address width (CPU_ADDR_BITS - log2(CPU_WIDTH/8)).
- MAX_OUTSTANDING, 4, maximum number of in-flight reads; tag FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset
- i_req_valid  in  1  I request valid
- i_req_ready  out  1  I request accepted this cycle
- i_req_addr  in  WORD_ADDR_BITS  I word address
- i_req_data  in  CPU_WIDTH  I write data
- i_req_write  in  4  I byte write mask; 0 = read
- i_resp_valid  out  1  I read response valid
- i_resp_data  out  CPU_WIDTH  I read data
- d_req_valid, d_req_ready, d_req_addr, d_req_data, d_req_write, d_resp_valid, d_resp_data: same as the I ports, for D
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  WORD_ADDR_BITS  forwarded address
- mem_req_data  out  CPU_WIDTH  forwarded write data
- mem_req_write  out  4  forwarded byte mask
- mem_resp_valid  in  1  memory read response valid
- mem_resp_data  in  CPU_WIDTH  memory read data
- resp_orphan  out  1  sticky error: a response arrived with no outstanding read

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On reset:
  - last_grant <= D;
  - tag FIFO emptied (count = 0, pointers = 0);
  - resp_orphan <= 0.
  - All outputs settle combinationally from these register values: req readies 0 unless the granted request can issue, resp valids 0 while mem_resp_valid = 0.
- Grant (combinational):
  - Only one requester valid -> that requester is granted.
  - Both valid -> grant the requester opposite last_grant.
  - last_grant updates only on an accepted handshake, so the grant stays stable while mem_req_ready = 0.
- Request forwarding:
  - mem_req_addr/data/write are muxed from the granted requester.
  - A request is "read" when write == 0.
  - blocked = granted request is a read and the FIFO is full (count == MAX_OUTSTANDING).
  - mem_req_valid = (i_req_valid | d_req_valid) & ~blocked.
  - x_req_ready = granted(x) & mem_req_ready & ~blocked. The non-granted requester's ready is 0.
- Accept: when mem_req_valid & mem_req_ready:
  - last_grant <= granted requester;
  - if the request is a read, push the requester ID (1 bit: 0 = I, 1 = D) into the tag FIFO;
  - writes push nothing.
- Response routing: when mem_resp_valid and the FIFO is non-empty:
  - pop the head;
  - assert x_resp_valid for the popped ID only, same cycle, combinationally;
  - i_resp_data = d_resp_data = mem_resp_data at all times.
- Orphan response: mem_resp_valid with the FIFO empty:
  - both resp valids stay 0;
  - response dropped;
  - resp_orphan <= 1 until reset.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full FIFO: read issue is blocked even if a pop occurs in the same cycle, so there is no comb path from mem_resp_valid to req_ready. Writes are never blocked by the FIFO.
- Ordering: responses return in issue order; the memory port must answer in order. No requester is starved: with both requesters continuously valid, they alternate on every accepted request.
- No state other than last_grant, the FIFO and resp_orphan; the block adds 0 cycles of latency in both directions.

Decomposition:
- Shared package/header: requester ID constants (REQ_I = 0, REQ_D = 1) and the write-mask width (4). Widths derive from CPU_INST_BITS/CPU_ADDR_BITS.
- One sub-module, mem_arb_tag_fifo: a 1-bit-wide, MAX_OUTSTANDING-deep synchronous FIFO with push, pop, full, empty and head, and an extra count bit so full and empty are distinguishable at wrap.

Test Plan:
- I-only read of addr 0x10 while memory returns 0xDEADBEEF one cycle later -> i_req_ready = 1 in the issue cycle, i_resp_valid = 1 with 0xDEADBEEF next cycle, d_resp_valid = 0 throughout.
- I and D both valid with reads for 6 consecutive cycles, mem_req_ready = 1 -> grants I, D, I, D, I, D; each response lands on the matching requester.
- D write (mask 0xF, data 0x12345678, addr 0x20), then I read of 0x20 -> no response for the write; I receives 0x12345678; FIFO count back to 0.
- mem_req_ready held 0 for 3 cycles with both requesters valid -> the granted requester and its address stay stable; no push occurs; the handshake happens on the first ready cycle.
- Memory withholds responses; issue 4 reads, then present a 5th read plus a write -> the read is blocked (ready = 0); the write is accepted; after one response the 5th read issues next cycle.
- mem_resp_valid pulsed with the FIFO empty -> no resp_valid on either requester, resp_orphan = 1 and sticky; reset clears it. Reset asserted with 2 reads outstanding -> FIFO empty after reset.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants for the instruction/data memory request arbiter.
package mem_req_arbiter_pkg;

  // Requester identity as stored in the read-response tag FIFO.
  typedef logic req_id_t;

  localparam req_id_t REQ_I = 1'b0;
  localparam req_id_t REQ_D = 1'b1;

  // Byte write-enable mask width; an all-zero mask marks a read.
  localparam int unsigned WMASK_BITS = 4;

  // Default geometry of the CPU memory interface.
  localparam int unsigned CPU_ADDR_BITS  = 32;
  localparam int unsigned CPU_INST_BITS  = 32;
  localparam int unsigned WORD_ADDR_BITS_DEFAULT = CPU_ADDR_BITS - $clog2(CPU_INST_BITS / 8);

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads. The count register is one bit wider
// than the pointers so full and empty stay distinguishable when the pointers wrap.
module mem_arb_tag_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  req_id_t push_id,
  output logic    full,
  output logic    empty,
  output req_id_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  req_id_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  // Pointer and occupancy tracking; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + (PTR_W + 1)'(1);
      else if (!push && pop) count_q <= count_q - (PTR_W + 1)'(1);
    end
  end

  // Tag storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_id;
  end

  // Status flags and head of queue.
  always_comb begin
    full  = (count_q == FULL_COUNT);
    empty = (count_q == '0);
    head  = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request port between an instruction (I) and a data
// (D) requester. Read responses are steered back by an in-order tag FIFO; zero added latency.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned CPU_WIDTH       = 32,
  parameter int unsigned WORD_ADDR_BITS  = 30,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req_valid,
  output logic                      i_req_ready,
  input  logic [WORD_ADDR_BITS-1:0] i_req_addr,
  input  logic [CPU_WIDTH-1:0]      i_req_data,
  input  logic [WMASK_BITS-1:0]     i_req_write,
  output logic                      i_resp_valid,
  output logic [CPU_WIDTH-1:0]      i_resp_data,
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic [WORD_ADDR_BITS-1:0] d_req_addr,
  input  logic [CPU_WIDTH-1:0]      d_req_data,
  input  logic [WMASK_BITS-1:0]     d_req_write,
  output logic                      d_resp_valid,
  output logic [CPU_WIDTH-1:0]      d_resp_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
  output logic [CPU_WIDTH-1:0]      mem_req_data,
  output logic [WMASK_BITS-1:0]     mem_req_write,
  input  logic                      mem_resp_valid,
  input  logic [CPU_WIDTH-1:0]      mem_resp_data,
  output logic                      resp_orphan
);

  req_id_t last_grant_q;
  logic    resp_orphan_q;

  req_id_t grant;
  logic    is_read, blocked, accept;
  logic    fifo_push, fifo_pop, fifo_full, fifo_empty;
  req_id_t fifo_head;

  // Round-robin grant: a lone requester wins, otherwise the one not served last.
  always_comb begin
    grant = REQ_I;
    if (i_req_valid && d_req_valid) begin
      grant = (last_grant_q == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req_valid) begin
      grant = REQ_D;
    end
  end

  // Forward the granted request; reads stall only while every tag slot is taken.
  always_comb begin
    mem_req_addr  = (grant == REQ_D) ? d_req_addr  : i_req_addr;
    mem_req_data  = (grant == REQ_D) ? d_req_data  : i_req_data;
    mem_req_write = (grant == REQ_D) ? d_req_write : i_req_write;
    is_read       = (mem_req_write == '0);
    // Uses registered full only, keeping mem_resp_valid out of the ready path.
    blocked       = is_read & fifo_full;
    mem_req_valid = (i_req_valid | d_req_valid) & ~blocked;
    accept        = mem_req_valid & mem_req_ready;
    i_req_ready   = i_req_valid & (grant == REQ_I) & mem_req_ready & ~blocked;
    d_req_ready   = d_req_valid & (grant == REQ_D) & mem_req_ready & ~blocked;
    fifo_push     = accept & is_read;
  end

  // Route each memory response to the requester at the head of the tag FIFO.
  always_comb begin
    fifo_pop     = mem_resp_valid & ~fifo_empty;
    i_resp_valid = fifo_pop & (fifo_head == REQ_I);
    d_resp_valid = fifo_pop & (fifo_head == REQ_D);
    i_resp_data  = mem_resp_data;
    d_resp_data  = mem_resp_data;
    resp_orphan  = resp_orphan_q;
  end

  // Round-robin history and sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= REQ_D;
      resp_orphan_q <= 1'b0;
    end else begin
      if (accept) last_grant_q <= grant;
      if (mem_resp_valid && fifo_empty) resp_orphan_q <= 1'b1;
    end
  end

  mem_arb_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .push_id(grant),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: requester queues and a memory model drive the DUT,
// expected read responses are queued at issue and popped by a monitor on every response.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int unsigned CW   = 32;
  localparam int unsigned AW   = 30;
  localparam int unsigned MAXO = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
    logic [3:0]    wr;
  } txn_t;

  typedef struct {
    req_id_t       id;
    logic [CW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_req_valid, i_req_ready, i_resp_valid;
  logic [AW-1:0] i_req_addr;
  logic [CW-1:0] i_req_data, i_resp_data;
  logic [3:0]    i_req_write;
  logic d_req_valid, d_req_ready, d_resp_valid;
  logic [AW-1:0] d_req_addr;
  logic [CW-1:0] d_req_data, d_resp_data;
  logic [3:0]    d_req_write;
  logic mem_req_valid, mem_req_ready, mem_resp_valid, resp_orphan;
  logic [AW-1:0] mem_req_addr;
  logic [CW-1:0] mem_req_data, mem_resp_data;
  logic [3:0]    mem_req_write;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .CPU_WIDTH(CW),
    .WORD_ADDR_BITS(AW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_req_data(i_req_data), .i_req_write(i_req_write),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_data(d_req_data), .d_req_write(d_req_write),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_write(mem_req_write),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .resp_orphan(resp_orphan)
  );

  // Knobs and model state
  int unsigned ready_pct = 100;
  int unsigned resp_pct  = 100;
  bit gate = 1'b0;
  bit orphan_pulse = 1'b0;
  bit i_done = 1'b0, d_done = 1'b0;
  bit log_en = 1'b0;
  bit orphan_exp = 1'b0;
  req_id_t mlast = REQ_D;
  txn_t iq[$], dq[$];
  exp_t sb[$];
  logic [CW-1:0] mem_pend[$];
  logic [CW-1:0] rmem[int];
  req_id_t grant_log[$];
  logic [CW-1:0] last_i_resp = '0;
  logic [CW-1:0] last_d_resp = '0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] rd(input logic [AW-1:0] a);
    if (rmem.exists(int'(a))) return rmem[int'(a)];
    return {2'b10, a} ^ 32'h5A5A_0000;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((iq.size() != 0 || dq.size() != 0 || sb.size() != 0) && k < budget) begin
      cyc(1);
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: waited %0d cycles, %0d reads still expected", k, sb.size());
    end
  endtask

  function automatic txn_t mk(input logic [AW-1:0] a, input logic [CW-1:0] d,
                              input logic [3:0] w);
    txn_t t;
    t.addr = a;
    t.data = d;
    t.wr   = w;
    return t;
  endfunction

  // Driver: requesters and memory model, updated just after each rising edge.
  initial begin
    i_req_valid = 0; i_req_addr = '0; i_req_data = '0; i_req_write = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_data = '0; d_req_write = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (i_done) begin iq.delete(0); i_done = 0; end
      if (d_done) begin dq.delete(0); d_done = 0; end
      i_req_valid = gate && iq.size() != 0;
      if (iq.size() != 0) begin
        i_req_addr = iq[0].addr; i_req_data = iq[0].data; i_req_write = iq[0].wr;
      end
      d_req_valid = gate && dq.size() != 0;
      if (dq.size() != 0) begin
        d_req_addr = dq[0].addr; d_req_data = dq[0].data; d_req_write = dq[0].wr;
      end
      mem_req_ready = ($urandom_range(99) < ready_pct);
      if (orphan_pulse) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
        orphan_pulse   = 1'b0;
      end else begin
        mem_resp_valid = (mem_pend.size() != 0) && ($urandom_range(99) < resp_pct);
        mem_resp_data  = mem_resp_valid ? mem_pend[0] : $urandom;
      end
    end
  end

  // Monitor: mid-cycle comparison of all DUT outputs against the reference model.
  initial begin
    bit      any, blk, go;
    req_id_t g;
    txn_t    cur;
    exp_t    e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        mem_pend.delete();
        mlast = REQ_D;
        orphan_exp = 1'b0;
      end else begin
        any = i_req_valid || d_req_valid;
        if (i_req_valid && d_req_valid) g = (mlast == REQ_I) ? REQ_D : REQ_I;
        else if (d_req_valid)           g = REQ_D;
        else                            g = REQ_I;
        cur = (g == REQ_I) ? mk(i_req_addr, i_req_data, i_req_write)
                           : mk(d_req_addr, d_req_data, d_req_write);
        blk = any && cur.wr == 4'd0 && sb.size() == MAXO;
        go  = any && !blk;
        chk("mem_req_valid", mem_req_valid, go);
        chk("i_req_ready", i_req_ready, go && mem_req_ready && g == REQ_I);
        chk("d_req_ready", d_req_ready, go && mem_req_ready && g == REQ_D);
        if (go) begin
          chk("mem_req_addr", mem_req_addr, cur.addr);
          chk("mem_req_data", mem_req_data, cur.data);
          chk("mem_req_write", mem_req_write, cur.wr);
        end
        chk("resp_orphan", resp_orphan, orphan_exp);
        if (mem_resp_valid) begin
          if (sb.size() == 0) begin
            chk("orphan_i_resp_valid", i_resp_valid, 1'b0);
            chk("orphan_d_resp_valid", d_resp_valid, 1'b0);
            orphan_exp = 1'b1;
          end else begin
            e = sb.pop_front();
            mem_pend.delete(0);
            chk("i_resp_valid", i_resp_valid, e.id == REQ_I);
            chk("d_resp_valid", d_resp_valid, e.id == REQ_D);
            if (e.id == REQ_I) begin
              chk("i_resp_data", i_resp_data, e.data);
              last_i_resp = i_resp_data;
            end else begin
              chk("d_resp_data", d_resp_data, e.data);
              last_d_resp = d_resp_data;
            end
          end
        end else begin
          chk("idle_i_resp_valid", i_resp_valid, 1'b0);
          chk("idle_d_resp_valid", d_resp_valid, 1'b0);
        end
        if (log_en && i_req_ready) grant_log.push_back(REQ_I);
        if (log_en && d_req_ready) grant_log.push_back(REQ_D);
        if (go && mem_req_ready) begin
          mlast = g;
          if (g == REQ_I) i_done = 1'b1;
          else            d_done = 1'b1;
          if (cur.wr != 4'd0) begin
            logic [CW-1:0] w;
            w = rd(cur.addr);
            for (int b = 0; b < 4; b++) if (cur.wr[b]) w[8*b +: 8] = cur.data[8*b +: 8];
            rmem[int'(cur.addr)] = w;
          end else begin
            sb.push_back('{g, rd(cur.addr)});
            mem_pend.push_back(rd(cur.addr));
          end
        end
      end
    end
  end

  // Main sequence: directed scenarios, then randomized traffic.
  initial begin
    cyc(3);
    reset = 1'b0;
    chk("reset_orphan", resp_orphan, 1'b0);
    chk("reset_mem_req_valid", mem_req_valid, 1'b0);
    cyc(1);
    gate = 1'b1;

    // Both requesters reading back-to-back must alternate starting with I.
    log_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iq.push_back(mk(AW'(32'h100 + k), '0, 4'd0));
      dq.push_back(mk(AW'(32'h200 + k), '0, 4'd0));
    end
    drain(100);
    log_en = 1'b0;
    chk("alt_grant_count", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
      chk("alt_grant", grant_log[k], (k % 2 == 1) ? REQ_D : REQ_I);
    end

    // Single I read.
    rmem[32'h10] = 32'hDEAD_BEEF;
    iq.push_back(mk(AW'(32'h10), '0, 4'd0));
    drain(50);
    chk("i_read_deadbeef", last_i_resp, 32'hDEAD_BEEF);

    // D write then I read of the same word.
    dq.push_back(mk(AW'(32'h20), 32'h1234_5678, 4'hF));
    drain(50);
    iq.push_back(mk(AW'(32'h20), '0, 4'd0));
    drain(50);
    chk("write_then_read", last_i_resp, 32'h1234_5678);

    // Memory stalls with both valid; grant must hold until ready returns.
    ready_pct = 0;
    iq.push_back(mk(AW'(32'h30), '0, 4'd0));
    dq.push_back(mk(AW'(32'h31), '0, 4'd0));
    cyc(3);
    chk("stall_no_accept", iq.size() + dq.size(), 2);
    ready_pct = 100;
    drain(50);

    // Fill the tag FIFO; a further read blocks while a write still goes through.
    resp_pct = 0;
    for (int k = 0; k < 4; k++) iq.push_back(mk(AW'(32'h40 + k), '0, 4'd0));
    cyc(6);
    iq.push_back(mk(AW'(32'h44), '0, 4'd0));
    dq.push_back(mk(AW'(32'h50), 32'hCAFE_F00D, 4'h3));
    cyc(4);
    chk("full_write_accepted", dq.size(), 0);
    chk("full_read_blocked", iq.size(), 1);
    resp_pct = 100;
    drain(50);

    // Orphan response is flagged and sticky.
    orphan_pulse = 1'b1;
    cyc(3);
    chk("orphan_set", resp_orphan, 1'b1);
    cyc(2);
    chk("orphan_sticky", resp_orphan, 1'b1);

    // Reset with two reads outstanding empties the FIFO and clears the flag.
    resp_pct = 0;
    iq.push_back(mk(AW'(32'h60), '0, 4'd0));
    iq.push_back(mk(AW'(32'h61), '0, 4'd0));
    cyc(5);
    gate = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    chk("reset_clears_orphan", resp_orphan, 1'b0);
    orphan_pulse = 1'b1;
    cyc(3);
    chk("fifo_empty_after_reset", resp_orphan, 1'b1);
    gate = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    resp_pct = 100;
    cyc(1);
    gate = 1'b1;

    // Randomized mixed traffic with random back-pressure and response delay.
    ready_pct = 70;
    resp_pct  = 60;
    for (int c = 0; c < 400; c++) begin
      if (iq.size() < 2 && $urandom_range(2) == 0)
        iq.push_back(mk(AW'($urandom_range(15)), $urandom,
                        ($urandom_range(2) == 0) ? 4'($urandom_range(15, 1)) : 4'd0));
      if (dq.size() < 2 && $urandom_range(2) == 0)
        dq.push_back(mk(AW'($urandom_range(15)), $urandom,
                        ($urandom_range(2) == 0) ? 4'($urandom_range(15, 1)) : 4'd0));
      cyc(1);
    end
    ready_pct = 100;
    resp_pct  = 100;
    drain(1000);
    chk("final_no_orphan", resp_orphan, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
